// File: rtl/aes_comp_dec.sv
// aes_comp_dec: iterative AES-128 decryption core, one round per clock.
module aes_comp_dec #(
  parameter int NR = 10
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         EN,
  input  logic [127:0] Kin,
  input  logic [127:0] Din,
  input  logic         Krdy,
  input  logic         Drdy,
  output logic [127:0] Dout,
  output logic         BSY,
  output logic         Kvld,
  output logic         Dvld,
  output logic [127:0] Dtrans
);
  typedef enum logic [1:0] {IDLE, KEYEXP, DEC} state_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = ginv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [NR-1:0] r);
    return r[7:0] | (r[8] ? 8'h1b : 8'h00) | (r[9] ? 8'h36 : 8'h00);
  endfunction

  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = isbox(s[127-8*(r+4*((c+4-r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {
        gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9),
        gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13),
        gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11),
        gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14)};
    end
    return o;
  endfunction

  state_t          state_q, state_d;
  logic [127:0]    drg_q, drg_d, krgx_q, krgx_d, k10_q, k10_d, hist_q;
  logic [NR-1:0]   rrg_q, rrg_d, rrev;
  logic            kvld_q, kvld_d, dvld_q, dvld_d;
  logic [31:0]     w0, w1, w2, w3, sw_in, sw;
  logic [7:0]      rc;
  logic [127:0]    kfwd, kinv, ark;

  assign {w0, w1, w2, w3} = krgx_q;
  // Decryption walks the Rcon sequence backwards, so index it with the reversed one-hot
  assign rrev  = {<<{rrg_q}};
  assign rc    = rcon(state_q == DEC ? rrev : rrg_q);
  assign sw_in = state_q == DEC ? w3 ^ w2 : w3;
  assign sw    = sub_word({sw_in[23:0], sw_in[31:24]}) ^ {rc, 24'h0};
  assign kfwd  = {w0 ^ sw, w1 ^ w0 ^ sw, w2 ^ w1 ^ w0 ^ sw, w3 ^ w2 ^ w1 ^ w0 ^ sw};
  assign kinv  = {w0 ^ sw, w1 ^ w0, w2 ^ w1, w3 ^ w2};
  assign ark   = inv_sub_shift(drg_q) ^ kinv;

  assign Dout   = drg_q;
  assign BSY    = state_q != IDLE;
  assign Kvld   = kvld_q;
  assign Dvld   = dvld_q;
  assign Dtrans = drg_q ^ hist_q;

  always_comb begin
    state_d = state_q;
    drg_d   = drg_q;
    krgx_d  = krgx_q;
    k10_d   = k10_q;
    rrg_d   = rrg_q;
    kvld_d  = kvld_q;
    dvld_d  = dvld_q;
    if (EN) begin
      case (state_q)
        IDLE: begin
          if (Krdy) begin
            krgx_d  = Kin;
            rrg_d   = NR'(1);
            kvld_d  = 1'b0;
            dvld_d  = 1'b0;
            state_d = KEYEXP;
          end else if (Drdy && kvld_q) begin
            drg_d   = Din ^ k10_q;
            krgx_d  = k10_q;
            rrg_d   = NR'(1);
            dvld_d  = 1'b0;
            state_d = DEC;
          end
        end
        KEYEXP: begin
          krgx_d = kfwd;
          rrg_d  = {rrg_q[NR-2:0], rrg_q[NR-1]};
          if (rrg_q[NR-1]) begin
            k10_d   = kfwd;
            kvld_d  = 1'b1;
            state_d = IDLE;
          end
        end
        DEC: begin
          drg_d  = rrg_q[NR-1] ? ark : inv_mix(ark);
          krgx_d = rrg_q[NR-1] ? k10_q : kinv;
          rrg_d  = {rrg_q[NR-2:0], rrg_q[NR-1]};
          if (rrg_q[NR-1]) begin
            dvld_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    hist_q <= RSTn ? drg_q : '0;
    if (!RSTn) begin
      state_q <= IDLE;
      drg_q   <= '0;
      krgx_q  <= '0;
      k10_q   <= '0;
      rrg_q   <= NR'(1);
      kvld_q  <= 1'b0;
      dvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drg_q   <= drg_d;
      krgx_q  <= krgx_d;
      k10_q   <= k10_d;
      rrg_q   <= rrg_d;
      kvld_q  <= kvld_d;
      dvld_q  <= dvld_d;
    end
  end
endmodule
